complex_mult_seq: RTL and testbench

Sequential signed complex multiplier for the E8 complex-arithmetic datapath. It sits directly upstream of the complex add/sub stage. It produces one packed complex product `{Re, Im}` in the same packed operand format that the add/sub stage consumes, so the two stages chain without reformatting. A single shared shift-add multiplier is time-multiplexed over the four partial products, which keeps area low at the cost of a fixed multi-cycle latency.

---
 rtl/complex_mult_seq_pkg.sv | 33 +++
 rtl/complex_mult_seq_if.sv | 35 +++
 rtl/complex_mult_seq_mult.sv | 82 ++++++++
 rtl/complex_mult_seq.sv | 173 +++++++++++++++++
 tb/tb_complex_mult_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/complex_mult_seq_pkg.sv
// complex_mult_seq_pkg
//   Shared definitions for the E8 complex datapath (this multiplier, the
//   downstream add/sub stage and their benches):
//     - CM_W          : default signed component width
//     - packed-operand macros: SIZE_SPEC, Re, Im, signedRe, signedIm
//       (Re in the upper half, Im in the lower half of a 2W-bit word)
//     - cm_state_t    : FSM state encoding
//   No ports.

`ifndef COMPLEX_MULT_SEQ_MACROS_SV
`define COMPLEX_MULT_SEQ_MACROS_SV
`define SIZE_SPEC(w)     [2*(w)-1:0]
`define Re(v, w)         v[2*(w)-1:(w)]
`define Im(v, w)         v[(w)-1:0]
`define signedRe(v, w)   $signed(v[2*(w)-1:(w)])
`define signedIm(v, w)   $signed(v[(w)-1:0])
`endif

package complex_mult_seq_pkg;

  // Default component width shared by the whole complex datapath.
  localparam int CM_W = 8;

  // Number of partial products per complex multiply.
  localparam int CM_NPROD = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_FINISH = 2'd2
  } cm_state_t;

endpackage

// File: rtl/complex_mult_seq_if.sv
// complex_mult_seq_if
//   Request/result bundle of the sequential complex multiplier.
//   Parameter W : component width (packed operand width is 2W).
//   Signals:
//     start : request a multiply (master -> slave)
//     a, b  : packed operands {Re, Im} (master -> slave)
//     out   : packed product {Re, Im} (slave -> master)
//     busy  : operation in progress (slave -> master)
//     done  : one-cycle result pulse (slave -> master)
//     ovf   : a component left the W-bit signed range (slave -> master)
//   Modports: master (requester), slave (multiplier).

interface complex_mult_seq_if
  import complex_mult_seq_pkg::*;
#(
  parameter int W = CM_W
);
  logic              start;
  logic `SIZE_SPEC(W) a;
  logic `SIZE_SPEC(W) b;
  logic `SIZE_SPEC(W) out;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (
    output start, a, b,
    input  out, busy, done, ovf
  );

  modport slave (
    input  start, a, b,
    output out, busy, done, ovf
  );
endinterface

// File: rtl/complex_mult_seq_mult.sv
// signed_mult_seq
//   Radix-2 shift-add signed multiplier. Works on magnitudes and applies the
//   product sign at the output.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     go       : load x/y and start (also restarts a running multiply)
//     x, y     : W-bit signed operands, sampled on the go edge
//     p        : 2W-bit signed product, valid while rdy is high
//     rdy      : one-cycle pulse exactly W cycles after go
//   Bit 0 of the multiplier is folded in on the load edge, so the remaining
//   W-1 bits finish W-1 edges later and the consumer captures p on the W-th
//   edge after go.

module signed_mult_seq
  import complex_mult_seq_pkg::*;
#(
  parameter int W = CM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic signed [W-1:0]   x,
  input  logic signed [W-1:0]   y,
  output logic signed [2*W-1:0] p,
  output logic                  rdy
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   x_u;
  logic [W-1:0]   y_u;
  logic [W-1:0]   x_mag;
  logic [W-1:0]   y_mag;

  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [2*W-1:0] acc_reg;
  logic [CW-1:0]  cnt_reg;
  logic           running_reg;
  logic           neg_reg;
  logic [2*W-1:0] acc_neg;

  assign x_u = x;
  assign y_u = y;

  // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits.
  assign x_mag = x_u[W-1] ? (~x_u + W'(1)) : x_u;
  assign y_mag = y_u[W-1] ? (~y_u + W'(1)) : y_u;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      running_reg <= 1'b0;
      neg_reg     <= 1'b0;
    end else if (go) begin
      mcand_reg   <= {W'(0), x_mag} << 1;
      mplier_reg  <= y_mag >> 1;
      acc_reg     <= y_mag[0] ? {W'(0), x_mag} : '0;
      cnt_reg     <= CW'(1);
      running_reg <= 1'b1;
      neg_reg     <= x_u[W-1] ^ y_u[W-1];
    end else if (running_reg && (cnt_reg != CW'(W))) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CW'(1);
    end else if (running_reg) begin
      // Result was presented this cycle; go quiet until the next go.
      running_reg <= 1'b0;
    end
  end

  assign acc_neg = ~acc_reg + {{(2*W-1){1'b0}}, 1'b1};
  assign p       = neg_reg ? acc_neg : acc_reg;
  assign rdy     = running_reg && (cnt_reg == CW'(W));

endmodule

// File: rtl/complex_mult_seq.sv
// complex_mult_seq
//   Sequential signed complex multiplier: out = a * b on packed {Re, Im}
//   operands, using one shared shift-add multiplier over the four partial
//   products ar*br, ai*bi, ar*bi, ai*br. Latency 4W+1 cycles.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset (aborts any operation)
//     bus : complex_mult_seq_if.slave (start, a, b, out, busy, done, ovf)
//   Build option:
//     COMPLEX_MULT_SATURATE_EN defined   -> components clamp to W-bit range
//     COMPLEX_MULT_SATURATE_EN undefined -> components wrap (low W bits)
//   ovf is identical in both builds.

module complex_mult_seq
  import complex_mult_seq_pkg::*;
#(
  parameter int W = CM_W
) (
  input  logic                clk,
  input  logic                rst,
  complex_mult_seq_if.slave   bus
);

  cm_state_t          state_reg;
  logic [1:0]         k_reg;
  logic `SIZE_SPEC(W) a_lat_reg;
  logic `SIZE_SPEC(W) b_lat_reg;
  logic [2*W-1:0]     prod_reg [CM_NPROD];
  logic `SIZE_SPEC(W) out_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               ovf_reg;

  logic `SIZE_SPEC(W)  src_a;
  logic `SIZE_SPEC(W)  src_b;
  logic [1:0]          sel;
  logic signed [W-1:0] mul_x;
  logic signed [W-1:0] mul_y;
  logic                mul_go;
  logic signed [2*W-1:0] mul_p;
  logic                mul_rdy;

  logic [2*W:0]        exact [2];
  logic [W-1:0]        reduced [2];
  logic [1:0]          comp_ovf;

  // Operand selection for the shared multiplier. The first product is
  // launched on the start edge, before the latches hold the operands, so
  // IDLE reads the bus directly. In MUL the next product (k+1) is launched
  // on the same edge that stores product k.
  always_comb begin
    src_a = a_lat_reg;
    src_b = b_lat_reg;
    sel   = k_reg + 2'd1;
    if (state_reg == ST_IDLE) begin
      src_a = bus.a;
      src_b = bus.b;
      sel   = 2'd0;
    end
    mul_x = `signedRe(src_a, W);
    mul_y = `signedRe(src_b, W);
    case (sel)
      2'd0: begin
        mul_x = `signedRe(src_a, W);
        mul_y = `signedRe(src_b, W);
      end
      2'd1: begin
        mul_x = `signedIm(src_a, W);
        mul_y = `signedIm(src_b, W);
      end
      2'd2: begin
        mul_x = `signedRe(src_a, W);
        mul_y = `signedIm(src_b, W);
      end
      default: begin
        mul_x = `signedIm(src_a, W);
        mul_y = `signedRe(src_b, W);
      end
    endcase
  end

  assign mul_go = ((state_reg == ST_IDLE) && bus.start) ||
                  ((state_reg == ST_MUL) && mul_rdy && (k_reg != 2'd3));

  signed_mult_seq #(
    .W (W)
  ) u_mult (
    .clk (clk),
    .rst (rst),
    .go  (mul_go),
    .x   (mul_x),
    .y   (mul_y),
    .p   (mul_p),
    .rdy (mul_rdy)
  );

  // Exact components need 2W+1 bits: (-2^(W-1))^2 + (-2^(W-1))^2 = 2^(2W-1).
  assign exact[0] = {prod_reg[0][2*W-1], prod_reg[0]} - {prod_reg[1][2*W-1], prod_reg[1]};
  assign exact[1] = {prod_reg[2][2*W-1], prod_reg[2]} + {prod_reg[3][2*W-1], prod_reg[3]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_reduce
      logic [W+1:0] top_bits;

      // In range iff bits [2W:W-1] are all copies of the sign.
      assign top_bits     = exact[gi][2*W:W-1];
      assign comp_ovf[gi] = !((&top_bits) || !(|top_bits));

`ifdef COMPLEX_MULT_SATURATE_EN
      assign reduced[gi] = !comp_ovf[gi]    ? exact[gi][W-1:0] :
                           exact[gi][2*W]   ? {1'b1, {(W-1){1'b0}}} :
                                              {1'b0, {(W-1){1'b1}}};
`else
      assign reduced[gi] = exact[gi][W-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= 2'd0;
      a_lat_reg <= '0;
      b_lat_reg <= '0;
      for (int i = 0; i < CM_NPROD; i++) begin
        prod_reg[i] <= '0;
      end
      out_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            a_lat_reg <= bus.a;
            b_lat_reg <= bus.b;
            k_reg     <= 2'd0;
            busy_reg  <= 1'b1;
            state_reg <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_rdy) begin
            prod_reg[k_reg] <= mul_p;
            if (k_reg == 2'd3) begin
              state_reg <= ST_FINISH;
            end else begin
              k_reg <= k_reg + 2'd1;
            end
          end
        end
        ST_FINISH: begin
          out_reg   <= {reduced[0], reduced[1]};
          ovf_reg   <= |comp_ovf;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out  = out_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_complex_mult_seq.sv
// tb_complex_mult_seq
//   Directed-vector bench for complex_mult_seq at W=8. Expected products are
//   hand-computed constants; saturating/wrapping expectations follow the
//   COMPLEX_MULT_SATURATE_EN build option.

module tb_complex_mult_seq;

  localparam int W   = 8;
  localparam int LAT = 4 * W + 1;

`ifdef COMPLEX_MULT_SATURATE_EN
  localparam logic [15:0] EXP_OVF2   = 16'h807f;  // (-128, 127)
  localparam logic [15:0] EXP_CORNER = 16'h7f7f;  // (127, 127)
  localparam logic [15:0] EXP_P128   = 16'h7f00;  // (127, 0)
`else
  localparam logic [15:0] EXP_OVF2   = 16'h3219;  // (50, 25)
  localparam logic [15:0] EXP_CORNER = 16'h0000;  // (0, 0)
  localparam logic [15:0] EXP_P128   = 16'h8000;  // (-128, 0)
`endif

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  complex_mult_seq_if #(.W(W)) bus ();

  complex_mult_seq #(
    .W (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done after the start edge. Optionally injects a
  // stray start with different operands at cycle 'poke', and optionally
  // checks that out keeps 'held' until done.
  task automatic wait_done(input int poke, input bit chk_hold, input logic [15:0] held,
                           output int lat, output bit busy_ok, output bit hold_ok);
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!bus.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (poke > 0 && lat == poke) begin
        bus.start = 1'b1;
        bus.a     = 16'h8080;
        bus.b     = 16'h8000;
      end else if (poke > 0 && lat == poke + 1) begin
        bus.start = 1'b0;
        bus.a     = 16'h1234;
      end
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
      if (chk_hold && !bus.done && bus.out !== held) hold_ok = 1'b0;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                       input logic [15:0] exp_out, input logic exp_ovf, input int poke);
    int lat;
    bit busy_ok;
    bit hold_ok;
    @(negedge clk);
    bus.a     = a_v;
    bus.b     = b_v;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk($sformatf("%s.busy_start", tag), 32'(bus.busy), 32'd1);
    wait_done(poke, 1'b0, 16'h0, lat, busy_ok, hold_ok);
    chk($sformatf("%s.latency", tag), 32'(lat), 32'(LAT));
    chk($sformatf("%s.busy_during", tag), 32'(busy_ok), 32'd1);
    chk($sformatf("%s.busy_at_done", tag), 32'(bus.busy), 32'd0);
    chk($sformatf("%s.out", tag), 32'(bus.out), 32'(exp_out));
    chk($sformatf("%s.ovf", tag), 32'(bus.ovf), 32'(exp_ovf));
    $display("op %s: a=%h b=%h out=%h ovf=%0d lat=%0d", tag, a_v, b_v, bus.out, bus.ovf, lat);
    @(posedge clk);
    #1;
    chk($sformatf("%s.done_pulse", tag), 32'(bus.done), 32'd0);
    chk($sformatf("%s.out_held", tag), 32'(bus.out), 32'(exp_out));
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit hold_ok;
    bit saw_done;
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.out", 32'(bus.out), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: (Re,Im) packed as {Re,Im}.
    do_op("basic",     16'h0304, 16'h05fe, 16'h170e, 1'b0, 0);   // (3,4)(5,-2)=(23,14)
    do_op("neg_ones",  16'hffff, 16'hffff, 16'h0002, 1'b0, 0);   // (-1,-1)^2=(0,2)
    do_op("min_exact", 16'hf000, 16'h0800, 16'h8000, 1'b0, 0);   // (-16)(8)=-128
    do_op("pos128",    16'h1000, 16'h0800, EXP_P128, 1'b1, 0);   // 16*8=128
    do_op("corner",    16'h8080, 16'h8000, EXP_CORNER, 1'b1, 0); // (16384,16384)
    do_op("busy_poke", 16'h0304, 16'h05fe, 16'h170e, 1'b0, 10);  // stray start ignored
    do_op("ovf2",      16'hf718, 16'h36ff, EXP_OVF2, 1'b1, 0);   // (-462,1305)

    // Reset mid-operation.
    @(negedge clk);
    bus.a     = 16'h0304;
    bus.b     = 16'h05fe;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.out", 32'(bus.out), 32'd0);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    chk("midrst.ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("midrst.no_done", 32'(saw_done), 32'd0);
    $display("op midrst: aborted, done seen=%0d", saw_done);
    do_op("after_rst", 16'h0000, 16'h0707, 16'h0000, 1'b0, 0);

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    bus.a     = 16'h0304;
    bus.b     = 16'h05fe;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(0, 1'b0, 16'h0, lat, busy_ok, hold_ok);
    chk("b2b1.latency", 32'(lat), 32'(LAT));
    chk("b2b1.out", 32'(bus.out), 32'h170e);
    $display("op b2b1: out=%h lat=%0d", bus.out, lat);
    bus.start = 1'b1;
    bus.a     = 16'hffff;
    bus.b     = 16'hffff;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b2.busy_start", 32'(bus.busy), 32'd1);
    chk("b2b2.done_low", 32'(bus.done), 32'd0);
    wait_done(0, 1'b1, 16'h170e, lat, busy_ok, hold_ok);
    chk("b2b2.latency", 32'(lat), 32'(LAT));
    chk("b2b2.busy_during", 32'(busy_ok), 32'd1);
    chk("b2b2.out_hold", 32'(hold_ok), 32'd1);
    chk("b2b2.out", 32'(bus.out), 32'h0002);
    chk("b2b2.ovf", 32'(bus.ovf), 32'd0);
    $display("op b2b2: out=%h lat=%0d", bus.out, lat);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
